// File: rtl/write_back_unit_if.sv
// rtl/write_back_unit_if.sv - MEM/WB retire handshake, register-file write port and forwarding bundle
interface write_back_unit_if #(
    parameter int COUNT_WIDTH = 32
);
    logic                   inValid;
    logic                   inReady;
    logic                   inRegWrite;
    logic                   inMemToReg;
    logic [4:0]             inWriteRegister;
    logic [31:0]            inAluResult;
    logic                   inMemReady;
    logic [31:0]            inMemData;
    logic                   regWrite;
    logic [4:0]             writeRegister;
    logic [31:0]            writeData;
    logic                   fwdValid;
    logic [4:0]             fwdRegister;
    logic [31:0]            fwdData;
    logic                   memTimeout;
    logic [COUNT_WIDTH-1:0] retiredCount;

    modport master (
        output inValid, inRegWrite, inMemToReg, inWriteRegister, inAluResult,
               inMemReady, inMemData,
        input  inReady, regWrite, writeRegister, writeData, fwdValid, fwdRegister,
               fwdData, memTimeout, retiredCount
    );

    modport slave (
        input  inValid, inRegWrite, inMemToReg, inWriteRegister, inAluResult,
               inMemReady, inMemData,
        output inReady, regWrite, writeRegister, writeData, fwdValid, fwdRegister,
               fwdData, memTimeout, retiredCount
    );
endinterface

// File: rtl/write_back_unit.sv
// rtl/write_back_unit.sv - MEM/WB register and write-back controller with load wait and timeout
module write_back_unit #(
    parameter int MEM_TIMEOUT = 15,
    parameter int COUNT_WIDTH = 32
) (
    input logic               clk,
    input logic               reset,
    write_back_unit_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        COMMIT   = 2'd2
    } state_t;

    // Abandon on the edge where the counter would reach MEM_TIMEOUT.
    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t                 state;
    state_t                 next_state;
    logic                   in_ready;
    logic                   accept;
    logic                   timeout_hit;
    logic [7:0]             wait_cnt;
    logic                   held_reg_write;
    logic [4:0]             held_dest;
    logic                   reg_write_q;
    logic [4:0]             write_register_q;
    logic [31:0]            write_data_q;
    logic                   mem_timeout_q;
    logic [COUNT_WIDTH-1:0] retired_q;

    always_comb begin
        in_ready    = (state != WAIT_MEM);
        accept      = bus.inValid && in_ready;
        timeout_hit = (state == WAIT_MEM) && !bus.inMemReady && (wait_cnt == TIMEOUT_LAST);
        next_state  = state;
        case (state)
            IDLE, COMMIT: begin
                if (accept)
                    next_state = (bus.inMemToReg && !bus.inMemReady) ? WAIT_MEM : COMMIT;
                else
                    next_state = IDLE;
            end
            WAIT_MEM: begin
                if (bus.inMemReady)
                    next_state = COMMIT;
                else if (wait_cnt == TIMEOUT_LAST)
                    next_state = IDLE;
                else
                    next_state = WAIT_MEM;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            wait_cnt         <= 8'd0;
            held_reg_write   <= 1'b0;
            held_dest        <= 5'd0;
            reg_write_q      <= 1'b0;
            write_register_q <= 5'd0;
            write_data_q     <= 32'd0;
            mem_timeout_q    <= 1'b0;
            retired_q        <= '0;
        end else begin
            state       <= next_state;
            reg_write_q <= 1'b0;
            if (state == COMMIT)
                retired_q <= retired_q + COUNT_WIDTH'(1);
            if (accept) begin
                held_reg_write <= bus.inRegWrite;
                held_dest      <= bus.inWriteRegister;
                wait_cnt       <= 8'd0;
                if (next_state == COMMIT) begin
                    reg_write_q      <= bus.inRegWrite && (bus.inWriteRegister != 5'd0);
                    write_register_q <= bus.inWriteRegister;
                    write_data_q     <= bus.inMemToReg ? bus.inMemData : bus.inAluResult;
                end
            end else if (state == WAIT_MEM) begin
                wait_cnt <= wait_cnt + 8'd1;
                if (bus.inMemReady) begin
                    reg_write_q      <= held_reg_write && (held_dest != 5'd0);
                    write_register_q <= held_dest;
                    write_data_q     <= bus.inMemData;
                end
                if (timeout_hit)
                    mem_timeout_q <= 1'b1;
            end
        end
    end

    // Forwarding taps the same registers the register file sees during COMMIT.
    assign bus.inReady       = in_ready;
    assign bus.regWrite      = reg_write_q;
    assign bus.writeRegister = write_register_q;
    assign bus.writeData     = write_data_q;
    assign bus.fwdValid      = reg_write_q;
    assign bus.fwdRegister   = write_register_q;
    assign bus.fwdData       = write_data_q;
    assign bus.memTimeout    = mem_timeout_q;
    assign bus.retiredCount  = retired_q;
endmodule

// File: tb/tb_write_back_unit.sv
// tb/tb_write_back_unit.sv - scoreboard bench for write_back_unit
module tb_write_back_unit;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;
    int   exp_cnt;
    logic [4:0]  exp_reg[$];
    logic [31:0] exp_data[$];

    write_back_unit_if #(.COUNT_WIDTH(32)) bus ();

    write_back_unit #(.MEM_TIMEOUT(15), .COUNT_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input bit v, input bit rw, input bit m2r, input logic [4:0] d,
                         input logic [31:0] alu, input bit mr, input logic [31:0] md);
        bus.inValid         = v;
        bus.inRegWrite      = rw;
        bus.inMemToReg      = m2r;
        bus.inWriteRegister = d;
        bus.inAluResult     = alu;
        bus.inMemReady      = mr;
        bus.inMemData       = md;
    endtask

    task automatic idle();
        drive(0, 0, 0, 5'd0, 32'd0, 0, 32'd0);
    endtask

    task automatic push(input logic [4:0] d, input logic [31:0] data);
        exp_reg.push_back(d);
        exp_data.push_back(data);
    endtask

    // Monitor: every observed register-file write must match the oldest expected one.
    always @(negedge clk) begin
        if (reset && bus.regWrite) begin
            if (exp_reg.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write: got reg %0d data 0x%08h expected no write at %0t",
                         bus.writeRegister, bus.writeData, $time);
            end else begin
                logic [4:0]  er;
                logic [31:0] ed;
                er = exp_reg.pop_front();
                ed = exp_data.pop_front();
                check("write_register", 32'(bus.writeRegister), 32'(er));
                check("write_data", bus.writeData, ed);
                check("fwd_valid", 32'(bus.fwdValid), 32'd1);
                check("fwd_register", 32'(bus.fwdRegister), 32'(er));
                check("fwd_data", bus.fwdData, ed);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        exp_cnt = 0;
        reset   = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #2;
        check("rst_in_ready", 32'(bus.inReady), 32'd1);
        check("rst_reg_write", 32'(bus.regWrite), 32'd0);
        check("rst_write_data", bus.writeData, 32'd0);
        check("rst_write_register", 32'(bus.writeRegister), 32'd0);
        check("rst_mem_timeout", 32'(bus.memTimeout), 32'd0);
        check("rst_retired", bus.retiredCount, 32'd0);
        reset = 1'b1;
        step();

        // ALU write to r8
        drive(1, 1, 0, 5'd8, 32'h0000_00AA, 0, 32'd0);
        push(5'd8, 32'h0000_00AA);
        step();
        idle();
        check("alu_retired_during_commit", bus.retiredCount, 32'd0);
        step();
        exp_cnt = 1;
        check("alu_retired", bus.retiredCount, 32'(exp_cnt));

        // back-to-back ALU writes
        for (int i = 1; i <= 4; i++) begin
            drive(1, 1, 0, 5'(i), 32'(8'h11 * i), 0, 32'd0);
            push(5'(i), 32'(8'h11 * i));
            check("b2b_in_ready", 32'(bus.inReady), 32'd1);
            step();
        end
        idle();
        step();
        exp_cnt += 4;
        check("b2b_retired", bus.retiredCount, 32'(exp_cnt));

        // load with memory ready three cycles after accept
        drive(1, 1, 1, 5'd9, 32'h0000_0BAD, 0, 32'd0);
        step();
        idle();
        check("load_wait1_in_ready", 32'(bus.inReady), 32'd0);
        step();
        check("load_wait2_in_ready", 32'(bus.inReady), 32'd0);
        step();
        check("load_wait3_in_ready", 32'(bus.inReady), 32'd0);
        drive(0, 0, 0, 5'd0, 32'd0, 1, 32'hDEAD_BEEF);
        push(5'd9, 32'hDEAD_BEEF);
        step();
        idle();
        step();
        exp_cnt += 1;
        check("load_retired", bus.retiredCount, 32'(exp_cnt));

        // load with memory ready in the accept cycle
        drive(1, 1, 1, 5'd10, 32'h0000_0BAD, 1, 32'h1234_5678);
        push(5'd10, 32'h1234_5678);
        step();
        idle();
        step();
        exp_cnt += 1;

        // r0 is never written; inRegWrite=0 never writes
        drive(1, 1, 0, 5'd0, 32'h0000_0005, 0, 32'd0);
        step();
        check("r0_reg_write", 32'(bus.regWrite), 32'd0);
        check("r0_write_data", bus.writeData, 32'h0000_0005);
        drive(1, 0, 0, 5'd7, 32'h0000_0077, 0, 32'd0);
        step();
        idle();
        check("nowrite_reg_write", 32'(bus.regWrite), 32'd0);
        check("nowrite_write_register", 32'(bus.writeRegister), 32'd7);
        step();
        exp_cnt += 2;
        check("nowrite_retired", bus.retiredCount, 32'(exp_cnt));

        // memory ready on the 15th wait cycle still commits
        drive(1, 1, 1, 5'd13, 32'd0, 0, 32'd0);
        step();
        idle();
        for (int i = 0; i < 14; i++) begin
            check("late_wait_in_ready", 32'(bus.inReady), 32'd0);
            step();
        end
        drive(0, 0, 0, 5'd0, 32'd0, 1, 32'hCAFE_F00D);
        push(5'd13, 32'hCAFE_F00D);
        check("late_last_in_ready", 32'(bus.inReady), 32'd0);
        step();
        idle();
        check("late_mem_timeout", 32'(bus.memTimeout), 32'd0);
        step();
        exp_cnt += 1;
        check("late_retired", bus.retiredCount, 32'(exp_cnt));

        // no memory response: abandon after 15 wait cycles
        drive(1, 1, 1, 5'd12, 32'd0, 0, 32'd0);
        step();
        idle();
        for (int i = 0; i < 15; i++) begin
            check("to_wait_in_ready", 32'(bus.inReady), 32'd0);
            step();
        end
        check("to_in_ready", 32'(bus.inReady), 32'd1);
        check("to_mem_timeout", 32'(bus.memTimeout), 32'd1);
        check("to_retired", bus.retiredCount, 32'(exp_cnt));
        drive(0, 0, 0, 5'd0, 32'd0, 1, 32'h0000_0099);
        step();
        idle();
        check("stray_ready_reg_write", 32'(bus.regWrite), 32'd0);
        step();
        check("stray_ready_retired", bus.retiredCount, 32'(exp_cnt));
        check("to_mem_timeout_sticky", 32'(bus.memTimeout), 32'd1);

        // asynchronous reset in the middle of a load
        drive(1, 1, 1, 5'd14, 32'd0, 0, 32'd0);
        step();
        idle();
        step();
        reset = 1'b0;
        #1;
        check("arst_reg_write", 32'(bus.regWrite), 32'd0);
        check("arst_write_register", 32'(bus.writeRegister), 32'd0);
        check("arst_write_data", bus.writeData, 32'd0);
        check("arst_mem_timeout", 32'(bus.memTimeout), 32'd0);
        check("arst_retired", bus.retiredCount, 32'd0);
        check("arst_in_ready", 32'(bus.inReady), 32'd1);
        step();
        reset = 1'b1;
        drive(0, 0, 0, 5'd0, 32'd0, 1, 32'h0000_0055);
        step();
        idle();
        step();
        check("arst_no_pending_commit", bus.retiredCount, 32'd0);
        drive(1, 1, 0, 5'd3, 32'h0000_0033, 0, 32'd0);
        push(5'd3, 32'h0000_0033);
        step();
        idle();
        step();
        check("post_rst_retired", bus.retiredCount, 32'd1);

        step();
        check("scoreboard_drained", 32'(exp_reg.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
